// File: rtl/writeback_stage.sv
// Write-back stage of the RV32I core: holds one retiring instruction,
// waits for the data-memory response on loads, extends load data and
// drives the register-file write port. Also counts retired instructions.
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    input  logic [1:0]       in_wb_sel,
    input  logic [XLEN-1:0]  in_alu_res,
    input  logic [XLEN-1:0]  in_pc_plus4,
    input  logic [2:0]       in_funct3,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [4:0]       a3,
    output logic             we3,
    output logic [XLEN-1:0]  wd,
    output logic             wb_busy,
    output logic             load_fault,
    output logic             stray_rvalid,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WRITE     = 2'd1,
        WAIT_LOAD = 2'd2
    } state_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_t           state_q, state_d;
    logic [4:0]       a3_q, a3_d;
    logic             we3_q, we3_d;
    logic [XLEN-1:0]  wd_q, wd_d;
    logic             load_fault_q, load_fault_d;
    logic             stray_q, stray_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    // Load attributes captured at accept, consumed when the response arrives.
    logic             rw_q, rw_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;

    logic             accept;
    logic             fault;

    // Select the addressed byte/halfword and extend it according to funct3.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      f3,
                                                    input logic [1:0]      off,
                                                    input logic [XLEN-1:0] rdata);
        logic [7:0]  bsel;
        logic [15:0] hsel;
        logic [XLEN-1:0] res;
        case (off)
            2'd0:    bsel = rdata[7:0];
            2'd1:    bsel = rdata[15:8];
            2'd2:    bsel = rdata[23:16];
            default: bsel = rdata[31:24];
        endcase
        hsel = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  res = {{24{bsel[7]}}, bsel};
            3'b100:  res = {24'h0, bsel};
            3'b001:  res = {{16{hsel[15]}}, hsel};
            3'b101:  res = {16'h0, hsel};
            3'b010:  res = rdata;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Misaligned halfword/word accesses and unused funct3 encodings fault.
    function automatic logic load_is_fault(input logic [2:0] f3, input logic [1:0] off);
        logic flt;
        case (f3)
            3'b000, 3'b100: flt = 1'b0;
            3'b001, 3'b101: flt = off[0];
            3'b010:         flt = (off != 2'd0);
            default:        flt = 1'b1;
        endcase
        return flt;
    endfunction

    assign in_ready = (state_q != WAIT_LOAD);
    assign wb_busy  = (state_q == WAIT_LOAD);
    assign accept   = in_valid && in_ready;
    assign fault    = load_is_fault(f3_q, off_q);

    // Next-state and next-output logic; WRITE always lasts a single cycle.
    always_comb begin
        state_d      = state_q;
        a3_d         = a3_q;
        we3_d        = 1'b0;
        wd_d         = wd_q;
        load_fault_d = 1'b0;
        stray_d      = dmem_rvalid && (state_q != WAIT_LOAD);
        retired_d    = retired_q + CNT_W'(state_q == WRITE);
        rw_d         = rw_q;
        f3_d         = f3_q;
        off_d        = off_q;
        case (state_q)
            EMPTY, WRITE: begin
                if (accept) begin
                    a3_d  = in_rd;
                    rw_d  = in_reg_write;
                    f3_d  = in_funct3;
                    off_d = in_alu_res[1:0];
                    if (in_wb_sel == SEL_LOAD) begin
                        state_d = WAIT_LOAD;
                    end else begin
                        state_d = WRITE;
                        we3_d   = in_reg_write && (in_rd != 5'd0) && (in_wb_sel != 2'b11);
                        case (in_wb_sel)
                            SEL_ALU: wd_d = in_alu_res;
                            SEL_PC4: wd_d = in_pc_plus4;
                            default: wd_d = '0;
                        endcase
                    end
                end else begin
                    state_d = EMPTY;
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    state_d      = WRITE;
                    wd_d         = load_extend(f3_q, off_q, dmem_rdata);
                    we3_d        = rw_q && (a3_q != 5'd0) && !fault;
                    load_fault_d = fault;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Control state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            a3_q         <= '0;
            we3_q        <= 1'b0;
            wd_q         <= '0;
            load_fault_q <= 1'b0;
            stray_q      <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            a3_q         <= a3_d;
            we3_q        <= we3_d;
            wd_q         <= wd_d;
            load_fault_q <= load_fault_d;
            stray_q      <= stray_d;
            retired_q    <= retired_d;
        end
    end

    // Captured load attributes are only read after being written, so no reset.
    always_ff @(posedge clk) begin
        rw_q  <= rw_d;
        f3_q  <= f3_d;
        off_q <= off_d;
    end

    assign a3           = a3_q;
    assign we3          = we3_q;
    assign wd           = wd_q;
    assign load_fault   = load_fault_q;
    assign stray_rvalid = stray_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_res;
    logic [31:0] in_pc_plus4;
    logic [2:0]  in_funct3;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  a3;
    logic        we3;
    logic [31:0] wd;
    logic        wb_busy;
    logic        load_fault;
    logic        stray_rvalid;
    logic [63:0] retired;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_retired = 64'd0;

    writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .in_wb_sel    (in_wb_sel),
        .in_alu_res   (in_alu_res),
        .in_pc_plus4  (in_pc_plus4),
        .in_funct3    (in_funct3),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .a3           (a3),
        .we3          (we3),
        .wd           (wd),
        .wb_busy      (wb_busy),
        .load_fault   (load_fault),
        .stray_rvalid (stray_rvalid),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          wait_c;
        logic        exp_we3;
        logic        chk_wd;
        logic [31:0] exp_wd;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                               input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
        in_valid     = 1'b1;
        in_rd        = rd;
        in_reg_write = rw;
        in_wb_sel    = sel;
        in_alu_res   = alu;
        in_pc_plus4  = pc4;
        in_funct3    = f3;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        drive_instr(v.rd, v.rw, v.sel, v.alu, v.pc4, v.f3);
        tick();
        in_valid = 1'b0;
        if (v.is_load) begin
            for (int i = 0; i < v.wait_c; i++) begin
                if (i > 0) tick();
                chk($sformatf("v%0d wb_busy", idx), 64'(wb_busy), 64'd1);
                chk($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'd0);
                chk($sformatf("v%0d we3_wait", idx), 64'(we3), 64'd0);
            end
            dmem_rvalid = 1'b1;
            dmem_rdata  = v.rdata;
            tick();
            dmem_rvalid = 1'b0;
            dmem_rdata  = 32'h0;
        end
        chk($sformatf("v%0d a3", idx), 64'(a3), 64'(v.rd));
        chk($sformatf("v%0d we3", idx), 64'(we3), 64'(v.exp_we3));
        if (v.chk_wd) chk($sformatf("v%0d wd", idx), 64'(wd), 64'(v.exp_wd));
        chk($sformatf("v%0d load_fault", idx), 64'(load_fault), 64'(v.exp_fault));
        exp_retired++;
        tick();
        chk($sformatf("v%0d retired", idx), retired, exp_retired);
        chk($sformatf("v%0d we3_after", idx), 64'(we3), 64'd0);
        chk($sformatf("v%0d fault_after", idx), 64'(load_fault), 64'd0);
    endtask

    initial begin
        //         load rd  rw  sel    alu           pc4          f3      rdata        wt we3 cwd exp_wd      flt
        vecs[0]  = '{0, 5'd5,  1, 2'b00, 32'h0000_1234, 32'h0,      3'b000, 32'h0,        0, 1, 1, 32'h0000_1234, 0};
        vecs[1]  = '{1, 5'd7,  1, 2'b01, 32'h0000_0103, 32'h0,      3'b000, 32'h80FF_FF00, 4, 1, 1, 32'hFFFF_FF80, 0};
        vecs[2]  = '{1, 5'd8,  1, 2'b01, 32'h0000_0202, 32'h0,      3'b101, 32'hBEEF_0000, 2, 1, 1, 32'h0000_BEEF, 0};
        vecs[3]  = '{1, 5'd9,  1, 2'b01, 32'h0000_0202, 32'h0,      3'b001, 32'hBEEF_0000, 1, 1, 1, 32'hFFFF_BEEF, 0};
        vecs[4]  = '{1, 5'd10, 1, 2'b01, 32'h0000_0302, 32'h0,      3'b010, 32'h1111_2222, 2, 0, 0, 32'h0,         1};
        vecs[5]  = '{0, 5'd0,  1, 2'b00, 32'h0000_0055, 32'h0,      3'b000, 32'h0,        0, 0, 0, 32'h0,         0};
        vecs[6]  = '{0, 5'd1,  1, 2'b10, 32'h0000_DEAD, 32'h0000_0104, 3'b000, 32'h0,     0, 1, 1, 32'h0000_0104, 0};
        vecs[7]  = '{1, 5'd11, 1, 2'b01, 32'h0000_0011, 32'h0,      3'b100, 32'h1234_5678, 3, 1, 1, 32'h0000_0056, 0};
        vecs[8]  = '{1, 5'd12, 1, 2'b01, 32'h0000_0400, 32'h0,      3'b010, 32'hCAFE_BABE, 1, 1, 1, 32'hCAFE_BABE, 0};
        vecs[9]  = '{1, 5'd13, 1, 2'b01, 32'h0000_0401, 32'h0,      3'b001, 32'hAAAA_5555, 1, 0, 0, 32'h0,         1};
        vecs[10] = '{1, 5'd14, 1, 2'b01, 32'h0000_0400, 32'h0,      3'b011, 32'h0123_4567, 2, 0, 0, 32'h0,         1};
        vecs[11] = '{0, 5'd3,  1, 2'b11, 32'h0000_0777, 32'h0,      3'b000, 32'h0,        0, 0, 0, 32'h0,         0};
        vecs[12] = '{0, 5'd4,  0, 2'b00, 32'h0000_0888, 32'h0,      3'b000, 32'h0,        0, 0, 0, 32'h0,         0};
        vecs[13] = '{1, 5'd15, 1, 2'b01, 32'h0000_0500, 32'h0,      3'b000, 32'hFFFF_FF7F, 1, 1, 1, 32'h0000_007F, 0};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_rd        = 5'd0;
        in_reg_write = 1'b0;
        in_wb_sel    = 2'b00;
        in_alu_res   = 32'h0;
        in_pc_plus4  = 32'h0;
        in_funct3    = 3'b000;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = 32'h0;

        repeat (3) tick();
        chk("rst a3", 64'(a3), 64'd0);
        chk("rst we3", 64'(we3), 64'd0);
        chk("rst wd", 64'(wd), 64'd0);
        chk("rst retired", retired, 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst wb_busy", 64'(wb_busy), 64'd0);
        chk("rst load_fault", 64'(load_fault), 64'd0);
        chk("rst stray", 64'(stray_rvalid), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) apply_vec(i, vecs[i]);

        // Three back-to-back ALU ops: we3 on consecutive cycles.
        drive_instr(5'd1, 1'b1, 2'b00, 32'h0000_0011, 32'h0, 3'b000);
        tick();
        chk("b2b0 a3", 64'(a3), 64'd1);
        chk("b2b0 we3", 64'(we3), 64'd1);
        chk("b2b0 wd", 64'(wd), 64'h11);
        chk("b2b0 in_ready", 64'(in_ready), 64'd1);
        drive_instr(5'd2, 1'b1, 2'b00, 32'h0000_0022, 32'h0, 3'b000);
        tick();
        chk("b2b1 a3", 64'(a3), 64'd2);
        chk("b2b1 we3", 64'(we3), 64'd1);
        chk("b2b1 wd", 64'(wd), 64'h22);
        drive_instr(5'd3, 1'b1, 2'b00, 32'h0000_0033, 32'h0, 3'b000);
        tick();
        in_valid = 1'b0;
        chk("b2b2 a3", 64'(a3), 64'd3);
        chk("b2b2 we3", 64'(we3), 64'd1);
        chk("b2b2 wd", 64'(wd), 64'h33);
        exp_retired += 3;
        tick();
        chk("b2b we3_end", 64'(we3), 64'd0);
        chk("b2b retired", retired, exp_retired);

        // Stray response while EMPTY: pulse, no write, no state change.
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid = 1'b0;
        chk("stray empty pulse", 64'(stray_rvalid), 64'd1);
        chk("stray empty we3", 64'(we3), 64'd0);
        chk("stray empty ready", 64'(in_ready), 64'd1);
        tick();
        chk("stray empty clear", 64'(stray_rvalid), 64'd0);
        chk("stray empty retired", retired, exp_retired);

        // Stray response during a WRITE cycle.
        drive_instr(5'd6, 1'b1, 2'b00, 32'h0000_0066, 32'h0, 3'b000);
        tick();
        in_valid    = 1'b0;
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        exp_retired++;
        chk("stray write pulse", 64'(stray_rvalid), 64'd1);
        chk("stray write we3", 64'(we3), 64'd0);
        chk("stray write busy", 64'(wb_busy), 64'd0);
        chk("stray write retired", retired, exp_retired);

        // Reset in the middle of a pending load.
        drive_instr(5'd20, 1'b1, 2'b01, 32'h0000_0000, 32'h0, 3'b010);
        tick();
        in_valid = 1'b0;
        chk("midrst busy_before", 64'(wb_busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_retired = 64'd0;
        chk("midrst a3", 64'(a3), 64'd0);
        chk("midrst wd", 64'(wd), 64'd0);
        chk("midrst we3", 64'(we3), 64'd0);
        chk("midrst retired", retired, 64'd0);
        chk("midrst busy", 64'(wb_busy), 64'd0);
        chk("midrst ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        tick();
        dmem_rvalid = 1'b0;
        chk("midrst stray", 64'(stray_rvalid), 64'd1);
        chk("midrst no write", 64'(we3), 64'd0);
        chk("midrst wd kept", 64'(wd), 64'd0);
        tick();
        chk("midrst retired_after", retired, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
